pe_dot_seq: RTL and testbench
=============================

PE_DOT_SEQ -- requirements
Module: pe_dot_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the element counter and of res_count.
REQ-002 SHALL have port clk, input, 1: clock; reset rst, synchronous, active-high.
REQ-003 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1: element pair valid.
REQ-005 SHALL have port in_ready, output, 1: sequencer accepts element pair.
REQ-006 SHALL have port in_a, input, 32: FP32 operand A.
REQ-007 SHALL have port in_b, input, 32: FP32 operand B.
REQ-008 SHALL have port in_last, input, 1: final element of the dot product.
REQ-009 SHALL have port pe_in_valid, output, 1: one-cycle issue pulse to the PE.
REQ-010 SHALL have ports pe_a_bits, pe_b_bits, pe_psum_in, each output, 32: operands and running sum to the PE.
REQ-011 SHALL have port pe_out_valid, input, 1: PE result pulse.
REQ-012 SHALL have port pe_psum_out, input, 32: PE result a*b+psum.
REQ-013 SHALL have ports res_valid, output, 1, and res_ready, input, 1: result handshake.
REQ-014 SHALL have port res_bits, output, 32: final FP32 dot product.
REQ-015 SHALL have port res_count, output, CNT_W: number of elements accumulated.
REQ-016 SHALL have port err_unexp, output, 1: sticky flag for a PE result that was not expected.

Function
REQ-017 SHALL implement states ACCEPT, ISSUE, WAIT_PE, DONE; in_ready = (state==ACCEPT).
REQ-018 In ACCEPT, in_valid&&in_ready SHALL latch in_a, in_b, in_last, increment the counter, and go to ISSUE.
REQ-019 In ISSUE, pe_in_valid SHALL be 1 for exactly one cycle, with pe_a_bits/pe_b_bits = latched operands and pe_psum_in = accumulator; the next state SHALL be WAIT_PE.
REQ-020 pe_a_bits, pe_b_bits and pe_psum_in SHALL stay stable from ISSUE until pe_out_valid.
REQ-021 In WAIT_PE, pe_out_valid SHALL load the accumulator with pe_psum_out; the next state SHALL be DONE if the latched last is set, else ACCEPT.
REQ-022 In DONE, res_valid SHALL be 1, with res_bits = accumulator and res_count = counter, all held stable until res_ready.
REQ-023 DONE with res_ready SHALL clear the accumulator to the initial value (REQ-030), clear the counter to 0, and return to ACCEPT.
REQ-024 Latency: the handshake edge is followed by pe_in_valid in the next cycle; the next in_ready SHALL follow the cycle after pe_out_valid.
REQ-025 The counter SHALL saturate at all-ones and never wrap.
REQ-026 pe_out_valid in any state other than WAIT_PE SHALL set err_unexp (sticky until rst) and SHALL be otherwise ignored.
REQ-027 The block SHALL perform no FP arithmetic itself; all values pass through bit-exact.

Reset
REQ-028 rst SHALL force state ACCEPT, set the accumulator to the initial value and the counter to 0, and drive all outputs to 0 (in_ready becomes 1 the cycle after rst deasserts). rst mid-operation SHALL abandon the sum; the PE shares rst.

Configuration
REQ-029 Macro PE_DOT_SEQ_BIAS_EN SHALL add an input port bias_bits, 32 bits.
REQ-030 With PE_DOT_SEQ_BIAS_EN defined, the initial accumulator SHALL be bias_bits, sampled on the first accepted element (counter==0) and used as that element's pe_psum_in; without it, the initial accumulator SHALL be 32'h00000000 and the port SHALL be absent.

Verification
REQ-031 Pairs (3F800000,40000000), then (40400000,40800000, last) -> one res_valid with res_bits=41600000 (14.0) and res_count=2.
REQ-032 Single pair (3FC00000,40000000, last) -> res_bits=40400000 and res_count=1; pe_in_valid is high exactly one cycle, one cycle after the accept edge.
REQ-033 Hold res_ready=0 for 5 cycles in DONE -> res_valid/res_bits/res_count remain stable and in_ready=0; on res_ready=1 the next dot product starts from 0.
REQ-034 Assert rst during WAIT_PE of element 2 of 3 -> all outputs are 0, in_ready=1 after release, and a new single pair 3F800000*3F800000 gives 3F800000.
REQ-035 Inject pe_out_valid in ACCEPT -> err_unexp=1 and stays 1; accumulator and state are unchanged.
REQ-036 With PE_DOT_SEQ_BIAS_EN, bias 3F800000 plus pair (40000000,40400000, last) -> res_bits=40E00000 (7.0).

Source files
------------

// File: rtl/pe_dot_seq.sv
// Sequencer that streams FP32 element pairs through an external multiply-add PE and returns the dot product.
// Optional build macro PE_DOT_SEQ_BIAS_EN adds bias_bits_i as the starting accumulator value.
module pe_dot_seq #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_a_i,
    input  logic [31:0]      in_b_i,
    input  logic             in_last_i,
`ifdef PE_DOT_SEQ_BIAS_EN
    input  logic [31:0]      bias_bits_i,
`endif
    output logic             pe_in_valid_o,
    output logic [31:0]      pe_a_bits_o,
    output logic [31:0]      pe_b_bits_o,
    output logic [31:0]      pe_psum_in_o,
    input  logic             pe_out_valid_i,
    input  logic [31:0]      pe_psum_out_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [31:0]      res_bits_o,
    output logic [CNT_W-1:0] res_count_o,
    output logic             err_unexp_o
);

    typedef enum logic [1:0] {StAccept, StIssue, StWaitPe, StDone} state_e;

    state_e            state_q, state_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic              last_q, last_d;
    logic [31:0]       acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [31:0]       init_acc;

`ifdef PE_DOT_SEQ_BIAS_EN
    assign init_acc = bias_bits_i;
`else
    assign init_acc = 32'h0000_0000;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        last_d  = last_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        // A PE result outside WAIT_PE is flagged and otherwise dropped.
        err_d   = err_q | (pe_out_valid_i && (state_q != StWaitPe));
        unique case (state_q)
            StAccept: begin
                if (in_valid_i) begin
                    a_d    = in_a_i;
                    b_d    = in_b_i;
                    last_d = in_last_i;
                    cnt_d  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
                    if (cnt_q == '0) begin
                        acc_d = init_acc;
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StWaitPe;
            end
            StWaitPe: begin
                if (pe_out_valid_i) begin
                    acc_d   = pe_psum_out_i;
                    state_d = last_q ? StDone : StAccept;
                end
            end
            StDone: begin
                if (res_ready_i) begin
                    acc_d   = 32'h0000_0000;
                    cnt_d   = '0;
                    state_d = StAccept;
                end
            end
            default: begin
                state_d = StAccept;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StAccept;
            a_q     <= 32'h0;
            b_q     <= 32'h0;
            last_q  <= 1'b0;
            acc_q   <= 32'h0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            last_q  <= last_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Held low while rst is asserted so every output reads 0 during reset.
    assign in_ready_o    = (state_q == StAccept) && !rst;
    assign pe_in_valid_o = (state_q == StIssue);
    assign pe_a_bits_o   = a_q;
    assign pe_b_bits_o   = b_q;
    assign pe_psum_in_o  = acc_q;
    assign res_valid_o   = (state_q == StDone);
    assign res_bits_o    = acc_q;
    assign res_count_o   = cnt_q;
    assign err_unexp_o   = err_q;

endmodule

// File: tb/tb_pe_dot_seq.sv
// Self-checking bench for pe_dot_seq: behavioural FP multiply-add PE plus a real-arithmetic dot-product model.
// Build with PE_DOT_SEQ_BIAS_EN defined to exercise the bias port as well.
module tb_pe_dot_seq;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_last;
    logic [31:0]   in_a, in_b;
    logic          pe_in_valid;
    logic [31:0]   pe_a, pe_b, pe_psum;
    logic          pe_out_valid = 1'b0;
    logic [31:0]   pe_psum_out = 32'h0;
    logic          res_valid, res_ready;
    logic [31:0]   res_bits;
    logic [CW-1:0] res_count;
    logic          err_unexp;
`ifdef PE_DOT_SEQ_BIAS_EN
    logic [31:0]   bias_bits = 32'h0;
`endif

    int n_cmp = 0;
    int n_err = 0;
    bit pe_hold = 1'b0;
    int inj_cnt = 0;
    int inj_seen = 0;

    always #5 clk = ~clk;

    pe_dot_seq #(.CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_a_i         (in_a),
        .in_b_i         (in_b),
        .in_last_i      (in_last),
`ifdef PE_DOT_SEQ_BIAS_EN
        .bias_bits_i    (bias_bits),
`endif
        .pe_in_valid_o  (pe_in_valid),
        .pe_a_bits_o    (pe_a),
        .pe_b_bits_o    (pe_b),
        .pe_psum_in_o   (pe_psum),
        .pe_out_valid_i (pe_out_valid),
        .pe_psum_out_i  (pe_psum_out),
        .res_valid_o    (res_valid),
        .res_ready_i    (res_ready),
        .res_bits_o     (res_bits),
        .res_count_o    (res_count),
        .err_unexp_o    (err_unexp)
    );

    function automatic real f2r(input logic [31:0] f);
        real r;
        int  e;
        if (f[30:0] == 31'd0) return 0.0;
        r = 1.0 + real'(f[22:0]) / 8388608.0;
        e = int'(f[30:23]) - 127;
        while (e > 0) begin r = r * 2.0; e--; end
        while (e < 0) begin r = r / 2.0; e++; end
        return f[31] ? -r : r;
    endfunction

    // Exact only for values representable in FP32, which is all this bench produces.
    function automatic logic [31:0] r2f(input real r_in);
        real    r;
        int     e;
        logic   s;
        longint m;
        r = r_in;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        if (s) r = -r;
        e = 0;
        while (r >= 2.0) begin r = r / 2.0; e++; end
        while (r < 1.0) begin r = r * 2.0; e--; end
        m = longint'((r - 1.0) * 8388608.0);
        return {s, 8'(e + 127), m[22:0]};
    endfunction

    // Behavioural PE: random latency, computes a*b+psum, aborts on reset.
    logic [31:0] cap_a, cap_b, cap_p;
    int          lat;
    bit          aborted;
    always begin : pe_model
        @(posedge clk); #2;
        if (rst) begin
            pe_out_valid = 1'b0;
        end else if (inj_cnt != inj_seen) begin
            inj_seen     = inj_cnt;
            pe_out_valid = 1'b1;
            pe_psum_out  = 32'h4B00_0000;
            @(posedge clk); #2;
            pe_out_valid = 1'b0;
        end else if (pe_in_valid === 1'b1) begin
            cap_a   = pe_a;
            cap_b   = pe_b;
            cap_p   = pe_psum;
            lat     = $urandom_range(0, 3);
            aborted = 1'b0;
            for (int i = 0; i <= lat && !aborted; i++) begin
                @(posedge clk); #2;
                if (rst) begin
                    aborted = 1'b1;
                end else begin
                    n_cmp++;
                    if (pe_in_valid !== 1'b0 || pe_a !== cap_a || pe_b !== cap_b ||
                        pe_psum !== cap_p) begin
                        n_err++;
                        $display("FAIL pe_operands_stable: got v=%b a=%h b=%h p=%h, required v=0 a=%h b=%h p=%h",
                                 pe_in_valid, pe_a, pe_b, pe_psum, cap_a, cap_b, cap_p);
                    end
                end
            end
            while (pe_hold && !aborted) begin
                @(posedge clk); #2;
                if (rst) aborted = 1'b1;
            end
            if (!aborted) begin
                pe_out_valid = 1'b1;
                pe_psum_out  = r2f(f2r(cap_a) * f2r(cap_b) + f2r(cap_p));
                @(posedge clk); #2;
                pe_out_valid = 1'b0;
            end
        end
    end

    task automatic send_pair(input logic [31:0] a, input logic [31:0] b, input logic last);
        int k;
        k = 0;
        while (in_ready !== 1'b1 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL accept_timeout: in_ready=%b, required 1", in_ready);
        end
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_res(output logic [31:0] bits, output logic [CW-1:0] cnt);
        int k;
        k = 0;
        while (res_valid !== 1'b1 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        n_cmp++;
        if (res_valid !== 1'b1) begin
            n_err++;
            $display("FAIL result_timeout: res_valid=%b, required 1", res_valid);
        end
        bits = res_bits;
        cnt  = res_count;
    endtask

    task automatic take_res();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, pe_in_valid, res_valid, err_unexp} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags: ready/pe_v/res_v/err=%b, required 0000",
                     {in_ready, pe_in_valid, res_valid, err_unexp});
        end
        n_cmp++;
        if ({pe_a, pe_b, pe_psum, res_bits} !== 128'h0 || res_count !== '0) begin
            n_err++;
            $display("FAIL reset_data: a=%h b=%h p=%h res=%h cnt=%0d, required all 0",
                     pe_a, pe_b, pe_psum, res_bits, res_count);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_two_pairs();
        logic [31:0]   bits;
        logic [CW-1:0] cnt;
        send_pair(32'h3F80_0000, 32'h4000_0000, 1'b0);
        send_pair(32'h4040_0000, 32'h4080_0000, 1'b1);
        wait_res(bits, cnt);
        n_cmp++;
        if (bits !== 32'h4160_0000 || cnt !== CW'(2)) begin
            n_err++;
            $display("FAIL two_pairs: res=%h cnt=%0d, required 41600000 cnt=2", bits, cnt);
        end
        take_res();
        n_cmp++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL two_pairs_release: res_valid=%b in_ready=%b, required 0 1",
                     res_valid, in_ready);
        end
    endtask

    task automatic test_single();
        logic [31:0]   bits;
        logic [CW-1:0] cnt;
        send_pair(32'h3FC0_0000, 32'h4000_0000, 1'b1);
        n_cmp++;
        if (pe_in_valid !== 1'b1) begin
            n_err++;
            $display("FAIL single_issue: pe_in_valid=%b after accept, required 1", pe_in_valid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (pe_in_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_issue_width: pe_in_valid=%b, required 0", pe_in_valid);
        end
        wait_res(bits, cnt);
        n_cmp++;
        if (bits !== 32'h4040_0000 || cnt !== CW'(1)) begin
            n_err++;
            $display("FAIL single: res=%h cnt=%0d, required 40400000 cnt=1", bits, cnt);
        end
        take_res();
    endtask

    task automatic test_hold();
        logic [31:0]   bits;
        logic [CW-1:0] cnt;
        send_pair(32'h4000_0000, 32'h4040_0000, 1'b1);
        wait_res(bits, cnt);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (res_valid !== 1'b1 || res_bits !== 32'h40C0_0000 || res_count !== CW'(1) ||
                in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL hold_stable: v=%b res=%h cnt=%0d rdy=%b, required 1 40c00000 1 0",
                         res_valid, res_bits, res_count, in_ready);
            end
            @(posedge clk); #1;
        end
        take_res();
        send_pair(32'h3F80_0000, 32'h3F80_0000, 1'b1);
        wait_res(bits, cnt);
        n_cmp++;
        if (bits !== 32'h3F80_0000 || cnt !== CW'(1)) begin
            n_err++;
            $display("FAIL hold_restart: res=%h cnt=%0d, required 3f800000 cnt=1", bits, cnt);
        end
        take_res();
    endtask

    task automatic test_saturate();
        logic [31:0]   bits;
        logic [CW-1:0] cnt;
        for (int i = 0; i < 9; i++) send_pair(32'h3F80_0000, 32'h3F80_0000, i == 8);
        wait_res(bits, cnt);
        n_cmp++;
        if (bits !== 32'h4110_0000 || cnt !== CW'(7)) begin
            n_err++;
            $display("FAIL saturate: res=%h cnt=%0d, required 41100000 cnt=7", bits, cnt);
        end
        take_res();
    endtask

    task automatic test_random();
        logic [31:0]   bits;
        logic [CW-1:0] cnt;
        int            n, a, b, sum, bias_int;
        for (int t = 0; t < 12; t++) begin
            n        = $urandom_range(1, 9);
            bias_int = 0;
`ifdef PE_DOT_SEQ_BIAS_EN
            bias_int  = $urandom_range(0, 15);
            bias_bits = r2f(real'(bias_int));
`endif
            sum = bias_int;
            for (int i = 0; i < n; i++) begin
                a = $urandom_range(0, 15);
                b = $urandom_range(0, 15);
                sum += a * b;
                send_pair(r2f(real'(a)), r2f(real'(b)), i == n - 1);
            end
            wait_res(bits, cnt);
            n_cmp++;
            if (bits !== r2f(real'(sum)) || cnt !== CW'((n > 7) ? 7 : n)) begin
                n_err++;
                $display("FAIL random_dot[%0d]: res=%h cnt=%0d, required %h cnt=%0d",
                         t, bits, cnt, r2f(real'(sum)), (n > 7) ? 7 : n);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            take_res();
        end
`ifdef PE_DOT_SEQ_BIAS_EN
        bias_bits = 32'h0;
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0]   bits;
        logic [CW-1:0] cnt;
        send_pair(32'h4000_0000, 32'h4000_0000, 1'b0);
        send_pair(32'h4040_0000, 32'h4040_0000, 1'b0);
        pe_hold = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({in_ready, pe_in_valid, res_valid, err_unexp} !== 4'b0000 ||
            {pe_a, pe_b, pe_psum, res_bits} !== 128'h0 || res_count !== '0) begin
            n_err++;
            $display("FAIL mid_reset_zero: rdy=%b pv=%b rv=%b err=%b a=%h b=%h p=%h res=%h cnt=%0d, required all 0",
                     in_ready, pe_in_valid, res_valid, err_unexp, pe_a, pe_b, pe_psum,
                     res_bits, res_count);
        end
        rst     = 1'b0;
        pe_hold = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset_ready: in_ready=%b, required 1", in_ready);
        end
        send_pair(32'h3F80_0000, 32'h3F80_0000, 1'b1);
        wait_res(bits, cnt);
        n_cmp++;
        if (bits !== 32'h3F80_0000 || cnt !== CW'(1)) begin
            n_err++;
            $display("FAIL mid_reset_restart: res=%h cnt=%0d, required 3f800000 cnt=1", bits, cnt);
        end
        take_res();
    endtask

    task automatic test_err();
        logic [31:0]   bits;
        logic [CW-1:0] cnt;
        n_cmp++;
        if (err_unexp !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL err_pre: err=%b rdy=%b, required 0 1", err_unexp, in_ready);
        end
        inj_cnt++;
        @(posedge clk); #1;
        n_cmp++;
        if (err_unexp !== 1'b1 || in_ready !== 1'b1 || res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL err_set: err=%b rdy=%b rv=%b, required 1 1 0",
                     err_unexp, in_ready, res_valid);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (err_unexp !== 1'b1 || pe_psum !== 32'h0) begin
            n_err++;
            $display("FAIL err_sticky: err=%b acc=%h, required 1 00000000", err_unexp, pe_psum);
        end
        send_pair(32'h4000_0000, 32'h4000_0000, 1'b1);
        wait_res(bits, cnt);
        n_cmp++;
        if (bits !== 32'h4080_0000 || cnt !== CW'(1) || err_unexp !== 1'b1) begin
            n_err++;
            $display("FAIL err_after: res=%h cnt=%0d err=%b, required 40800000 1 1",
                     bits, cnt, err_unexp);
        end
        take_res();
    endtask

`ifdef PE_DOT_SEQ_BIAS_EN
    task automatic test_bias();
        logic [31:0]   bits;
        logic [CW-1:0] cnt;
        bias_bits = 32'h3F80_0000;
        send_pair(32'h4000_0000, 32'h4040_0000, 1'b1);
        wait_res(bits, cnt);
        n_cmp++;
        if (bits !== 32'h40E0_0000 || cnt !== CW'(1)) begin
            n_err++;
            $display("FAIL bias: res=%h cnt=%0d, required 40e00000 cnt=1", bits, cnt);
        end
        take_res();
        bias_bits = 32'h0;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 32'h0;
        in_b      = 32'h0;
        in_last   = 1'b0;
        res_ready = 1'b0;
        test_reset();
        test_two_pairs();
        test_single();
        test_hold();
        test_saturate();
        test_random();
        test_reset_mid();
        test_err();
`ifdef PE_DOT_SEQ_BIAS_EN
        test_bias();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
